// File: rtl/uart_rx_fifo_if.sv
// Bus between the UART receiver/APB register block (master) and the receive FIFO (slave).
// Port names follow the receiver and register-block signal names.
interface uart_rx_fifo_if #(
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]  rx_data;
  logic        rx_done;
  logic        parity_error;
  logic        rd_en;
  logic        flush;
  logic        ovr_clr;
  logic [AW:0] thresh;

  logic [7:0]  rd_data;
  logic        rd_perr;
  logic        empty;
  logic        full;
  logic [AW:0] count;
  logic        overrun;
  logic        level_irq;

  modport master (
    output rx_data, rx_done, parity_error, rd_en, flush, ovr_clr, thresh,
    input  rd_data, rd_perr, empty, full, count, overrun, level_irq
  );

  modport slave (
    input  rx_data, rx_done, parity_error, rd_en, flush, ovr_clr, thresh,
    output rd_data, rd_perr, empty, full, count, overrun, level_irq
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive FIFO between the UART receiver and the APB register block: stores {parity, data},
// presents the oldest entry show-ahead, and reports fill level, threshold and overrun status.
module uart_rx_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input logic           clk,
  input logic           rst_n,
  uart_rx_fifo_if.slave bus
);

  logic [8:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic          overrun_q, overrun_d;

  logic empty, full;
  logic pop_ok, push_ok, drop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));

  // A pop frees a slot in the same cycle, so a push into a full FIFO is accepted
  // only when paired with a valid pop; while empty the pop is ignored instead.
  assign pop_ok  = bus.rd_en && !empty;
  assign push_ok = bus.rx_done && (!full || pop_ok);
  assign drop    = bus.rx_done && full && !pop_ok;

  // NOTE: always_comb with a default for every output up front cannot infer a latch.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;

    if (bus.flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      overrun_d = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);

      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase

      // Set wins over a same-cycle clear.
      if (drop)             overrun_d = 1'b1;
      else if (bus.ovr_clr) overrun_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; entries are only read behind a valid count.
  always_ff @(posedge clk) begin
    if (rst_n && !bus.flush && push_ok) begin
      mem_q[wr_ptr_q] <= {bus.parity_error, bus.rx_data};
    end
  end

  assign bus.rd_data   = mem_q[rd_ptr_q][7:0];
  assign bus.rd_perr   = mem_q[rd_ptr_q][8];
  assign bus.empty     = empty;
  assign bus.full      = full;
  assign bus.count     = count_q;
  assign bus.overrun   = overrun_q;
  assign bus.level_irq = (bus.thresh != '0) && (count_q >= bus.thresh);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a queue holds the expected {perr, data} of every
// accepted character and is compared against the head whenever the bench pops.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [8:0] sb_q [$];

  uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked before the next one.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic p);
    bus.rx_data      = d;
    bus.parity_error = p;
    bus.rx_done      = 1'b1;
    sb_q.push_back({p, d});
    tick();
    bus.rx_done      = 1'b0;
    bus.parity_error = 1'b0;
  endtask

  task automatic pop(input string tag);
    logic [8:0] exp;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
    end else begin
      exp = sb_q.pop_front();
      check(tag, {23'd0, bus.rd_perr, bus.rd_data}, {23'd0, exp});
    end
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
  endtask

  initial begin
    logic [8:0] exp;
    rst_n            = 1'b0;
    bus.rx_data      = '0;
    bus.rx_done      = 1'b0;
    bus.parity_error = 1'b0;
    bus.rd_en        = 1'b0;
    bus.flush        = 1'b0;
    bus.ovr_clr      = 1'b0;
    bus.thresh       = '0;
    tick();
    tick();
    rst_n = 1'b1;

    // 1: reset state and ordering
    check("rst_empty", 32'(bus.empty), 1);
    check("rst_count", 32'(bus.count), 0);
    check("rst_full", 32'(bus.full), 0);
    check("rst_overrun", 32'(bus.overrun), 0);
    check("rst_level", 32'(bus.level_irq), 0);
    push(8'h41, 1'b0);
    check("order_empty", 32'(bus.empty), 0);
    push(8'h42, 1'b0);
    push(8'h43, 1'b0);
    check("order_count", 32'(bus.count), 3);
    for (int i = 0; i < 3; i++) pop("order_rd");
    check("order_empty_end", 32'(bus.empty), 1);

    // 2: fill, overrun, set-wins-over-clear, drain, clear
    for (int i = 0; i < DEPTH; i++) push(8'(i), 1'b0);
    check("fill_full", 32'(bus.full), 1);
    check("fill_count", 32'(bus.count), DEPTH);
    bus.rx_data = 8'hAA;
    bus.rx_done = 1'b1;
    tick();
    bus.rx_done = 1'b0;
    check("ovr_set", 32'(bus.overrun), 1);
    check("ovr_count", 32'(bus.count), DEPTH);
    bus.ovr_clr = 1'b0;
    tick();
    bus.ovr_clr = 1'b1;
    bus.rx_done = 1'b1;
    tick();
    bus.ovr_clr = 1'b0;
    bus.rx_done = 1'b0;
    check("ovr_set_wins", 32'(bus.overrun), 1);
    for (int i = 0; i < DEPTH; i++) pop("fill_rd");
    check("fill_drained", 32'(bus.empty), 1);
    check("ovr_sticky", 32'(bus.overrun), 1);
    bus.ovr_clr = 1'b1;
    tick();
    bus.ovr_clr = 1'b0;
    check("ovr_clr", 32'(bus.overrun), 0);

    // 3: full with simultaneous push and pop
    for (int i = 0; i < DEPTH; i++) push(8'h10 + 8'(i), 1'b0);
    exp = sb_q.pop_front();
    check("fullpp_head", {23'd0, bus.rd_perr, bus.rd_data}, {23'd0, exp});
    bus.rx_data = 8'h55;
    bus.rx_done = 1'b1;
    bus.rd_en   = 1'b1;
    sb_q.push_back({1'b0, 8'h55});
    tick();
    bus.rx_done = 1'b0;
    bus.rd_en   = 1'b0;
    check("fullpp_count", 32'(bus.count), DEPTH);
    check("fullpp_overrun", 32'(bus.overrun), 0);
    for (int i = 0; i < DEPTH; i++) pop("fullpp_rd");
    check("fullpp_empty", 32'(bus.empty), 1);

    // 4: parity tagging across pointer wrap
    for (int i = 0; i < 20; i++) begin
      if (i == 17) push(8'h5A, 1'b1);
      else         push(8'h60 + 8'(i), 1'b0);
      pop("wrap_rd");
    end
    check("wrap_empty", 32'(bus.empty), 1);

    // 5: threshold, flush priority, pop while empty
    bus.thresh = 5'd4;
    for (int i = 0; i < 3; i++) push(8'h70 + 8'(i), 1'b0);
    check("lvl_below", 32'(bus.level_irq), 0);
    push(8'h73, 1'b0);
    check("lvl_at", 32'(bus.level_irq), 1);
    bus.thresh = 5'd20;
    #1;
    check("lvl_over_depth", 32'(bus.level_irq), 0);
    bus.thresh = 5'd4;
    bus.flush   = 1'b1;
    bus.rx_data = 8'h99;
    bus.rx_done = 1'b1;
    tick();
    bus.flush   = 1'b0;
    bus.rx_done = 1'b0;
    sb_q.delete();
    check("flush_count", 32'(bus.count), 0);
    check("flush_empty", 32'(bus.empty), 1);
    check("flush_level", 32'(bus.level_irq), 0);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check("rd_empty_count", 32'(bus.count), 0);
    check("rd_empty_empty", 32'(bus.empty), 1);
    check("rd_empty_ovr", 32'(bus.overrun), 0);
    push(8'h77, 1'b0);
    pop("after_flush_rd");
    bus.thresh = '0;

    // 6: reset mid-traffic with a concurrent push
    for (int i = 0; i < DEPTH; i++) push(8'h80 + 8'(i), 1'b0);
    bus.rx_done = 1'b1;
    tick();
    bus.rx_done = 1'b0;
    for (int i = 0; i < DEPTH - 5; i++) pop("mid_rd");
    check("mid_count5", 32'(bus.count), 5);
    check("mid_ovr_pre", 32'(bus.overrun), 1);
    rst_n       = 1'b0;
    bus.rx_data = 8'hEE;
    bus.rx_done = 1'b1;
    tick();
    rst_n       = 1'b1;
    bus.rx_done = 1'b0;
    sb_q.delete();
    check("mid_count", 32'(bus.count), 0);
    check("mid_empty", 32'(bus.empty), 1);
    check("mid_overrun", 32'(bus.overrun), 0);
    push(8'h12, 1'b0);
    check("mid_count1", 32'(bus.count), 1);
    pop("mid_after_rd");
    check("mid_empty_end", 32'(bus.empty), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer between the UART receiver and the APB register interface. It captures each character the receiver completes, together with that character's parity-error flag. It presents the oldest entry show-ahead to the register block and reports fill level, threshold and overrun status for interrupt generation.

## Interface

**Parameters**
- `DEPTH`, 16: number of entries; power of two, minimum 2.
- `AW`, `$clog2(DEPTH)`: pointer width; derived, never overridden.

**Ports**
- `clk`, input, 1: single clock for all state.
- `rst_n`, input, 1: reset, synchronous and active-low; sampled only on the rising edge of `clk`.
- `rx_data`, input, 8: character from the receiver; unused upper bits are zero.
- `rx_done`, input, 1: one-cycle push strobe from the receiver.
- `parity_error`, input, 1: parity flag from the receiver; stored alongside `rx_data`.
- `rd_en`, input, 1: pop strobe from the APB data-register read.
- `flush`, input, 1: synchronous clear of contents and status.
- `ovr_clr`, input, 1: clears the sticky overrun flag.
- `thresh`, input, AW+1: fill-level threshold; 0 disables the level flag.
- `rd_data`, output, 8: head entry data.
- `rd_perr`, output, 1: head entry parity-error flag.
- `empty`, output, 1: FIFO holds no entries.
- `full`, output, 1: FIFO holds `DEPTH` entries.
- `count`, output, AW+1: number of entries, 0..DEPTH.
- `overrun`, output, 1: sticky; a character was dropped.
- `level_irq`, output, 1: `count >= thresh` and `thresh != 0`.

## Operation

- **Storage:** `DEPTH` x 9-bit array holding {parity_error, rx_data}. Write and read pointers are AW bits and wrap modulo `DEPTH`. `count` is a separate register; no pointer-difference arithmetic.
- **Push:** on `rx_done`, if not full or if a valid pop occurs in the same cycle, write the entry at the write pointer and increment the write pointer.
- **Pop:** on `rd_en` while not empty, increment the read pointer. `rd_en` while empty has no effect: no pointer change, no error flag.
- **Simultaneous push and pop:**
  - While full: both occur, `count` is unchanged, no overrun.
  - While empty: only the push occurs, and `count` becomes 1.
  - Otherwise: both occur and `count` is unchanged.
- **Overrun:** `rx_done` while full with no valid pop drops the character. The array and pointers are unchanged and `overrun` is set. It stays set until `ovr_clr` or `flush`. If set and clear occur in the same cycle, set wins.
- **Flush:** takes priority over push and pop in the same cycle. Pointers, `count` and `overrun` go to 0, and the pushed character is discarded. Array contents are not cleared.
- **Status derivation:**
  - `empty = (count == 0)` and `full = (count == DEPTH)`, both derived from registered `count`.
  - `rd_data`/`rd_perr` show the array entry at the read pointer and are only meaningful while `!empty`.
  - `level_irq` is combinational from `count` and `thresh`. A `thresh` larger than `DEPTH` never asserts it.

## Timing

- **Reset** (`rst_n` low at a rising edge): pointers 0, `count` 0, `overrun` 0. Outputs after that edge: `empty` 1, `full` 0, `level_irq` 0, `count` 0. `rd_data`/`rd_perr` are undefined because `empty` is 1. Reset asserted mid-traffic discards all entries on that edge, and strobes in the same cycle are ignored.
- **Push-to-read latency:** 1 cycle. For `rx_done` at edge N, `empty` deasserts and `rd_data` is valid from edge N onward (cycle N+1).
- **Pop:** for `rd_en` at edge N, the next entry appears on `rd_data` after edge N. The consumer samples `rd_data` in the same cycle it asserts `rd_en`.
- **Back-to-back strobes:** `rx_done` and `rd_en` may each assert every cycle; there is no handshake back to the receiver.
- **Wrap-around:** pointers roll from `DEPTH-1` to 0 with no bubble cycle.

## Test plan

1. **Reset and order:** after reset, `empty`=1 and `count`=0. Push 0x41, 0x42, 0x43 on consecutive cycles, then pop 3 -> reads 0x41, 0x42, 0x43 in order, `rd_perr`=0, `empty`=1 after the third pop.
2. **Fill and overrun:** push 16 entries (0x00..0x0F) -> `full`=1, `count`=16. A 17th push of 0xAA -> `overrun`=1 and 0xAA is dropped. Popping 16 returns 0x00..0x0F exactly. `ovr_clr` -> `overrun`=0.
3. **Full with simultaneous push and pop:** when full, push 0x55 and pop together -> `count` stays 16, `overrun` stays 0, and 0x55 is read last after draining.
4. **Parity tagging across wrap:** push 20 characters, popping as you go, with `parity_error`=1 on the 18th (0x5A) -> it reads back as 0x5A with `rd_perr`=1 after pointer wrap, and every other entry has `rd_perr`=0.
5. **Threshold, flush and priority:**
   - `thresh`=4, push 3 -> `level_irq`=0; a 4th push -> `level_irq`=1.
   - `flush` together with `rx_done` -> `count`=0, `empty`=1, `level_irq`=0.
   - `rd_en` while empty -> no change.
6. **Mid-operation reset:** with 5 entries and `overrun`=1, drive `rst_n` low for one edge concurrently with `rx_done` -> `count`=0, `empty`=1, `overrun`=0, and the pushed character is absent.
